imem_responder: RTL and testbench



---
 rtl/imem_responder.sv | 179 +++++++++++++++++
 tb/tb_imem_responder.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// imem_responder: instruction-memory responder between the fetch stage and a
// word-addressed instruction store, with a fixed accept-to-response latency.
//
// Parameters: DEPTH_LOG2 (store depth, log2 words), BASE_ADDR (byte address
//   of word 0), LATENCY (1..15 cycles), RESET_INST (rsp_inst when idle).
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   req_valid/ready   fetch request handshake, req_addr = byte address
//   rsp_valid/ready   response handshake, rsp_inst / rsp_err payload
//   ld_wen/addr/data  preload write port into the store (any state)
//   busy              a request is outstanding
// Optional feature: define IMEM_BOUNDS_CHECK_EN to fault misaligned or
//   unmapped fetches (rsp_err=1, rsp_inst=ebreak); otherwise indices wrap.
module imem_responder #(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          LATENCY    = 1,
    parameter logic [31:0] RESET_INST = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_inst,
    output logic                  rsp_err,
    input  logic                  ld_wen,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [31:0]           ld_data,
    output logic                  busy
);

    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);
    localparam int          DEPTH  = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_cnt;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic                  r_fault;
    logic [31:0]           r_inst;
    logic                  r_err;
    logic [31:0]           r_mem [DEPTH];

    logic [31:0]           w_off;
    logic [DEPTH_LOG2-1:0] w_req_idx;
    logic [DEPTH_LOG2-1:0] w_rd_idx;
    logic                  w_fault;
    logic                  w_rd_fault;
    logic                  w_acc;
    logic                  w_enter;
    logic                  w_done;
    logic                  w_unused;

    assign w_off     = req_addr - BASE_ADDR;
    assign w_req_idx = w_off[DEPTH_LOG2+1:2];

`ifdef IMEM_BOUNDS_CHECK_EN
    // 33-bit span so the compare stays exact for very large stores.
    localparam logic [32:0] SPAN = 33'(DEPTH) << 2;
    assign w_fault  = (req_addr[1:0] != 2'b00) || ({1'b0, w_off} >= SPAN);
    assign w_unused = ^w_off[1:0];
`else
    assign w_fault  = 1'b0;
    assign w_unused = ^{w_off[31:DEPTH_LOG2+2], w_off[1:0]};
`endif

    assign w_acc  = req_valid & req_ready;
    assign w_done = (r_state == S_RESP) && rsp_ready;

    // With LATENCY==1 the store is read on the accepting edge itself, so
    // the live request drives the read; otherwise the captured copy does.
    assign w_enter    = (LATENCY == 1) ? w_acc
                      : ((r_state == S_WAIT) && (r_cnt == 4'd1));
    assign w_rd_idx   = (LATENCY == 1) ? w_req_idx : r_idx;
    assign w_rd_fault = (LATENCY == 1) ? w_fault : r_fault;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    w_next = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    if (w_acc) begin
                        w_next = (LATENCY == 1) ? S_RESP : S_WAIT;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            S_WAIT: begin
                busy = 1'b1;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                req_ready = rsp_ready;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_fault <= 1'b0;
            r_inst  <= RESET_INST;
            r_err   <= 1'b0;
        end else begin
            if (w_acc) begin
                r_cnt   <= LAT_M1;
                r_idx   <= w_req_idx;
                r_fault <= w_fault;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // Read sees pre-edge store contents: a same-edge load is ignored.
            if (w_enter) begin
                r_err  <= w_rd_fault;
                r_inst <= w_rd_fault ? EBREAK : r_mem[w_rd_idx];
            end else if (w_done) begin
                r_inst <= RESET_INST;
                r_err  <= 1'b0;
            end
        end
    end

    // The store is deliberately not reset so preloaded programs survive.
    always_ff @(posedge clk) begin
        if (ld_wen) begin
            r_mem[ld_addr] <= ld_data;
        end
    end

    assign rsp_inst = r_inst;
    assign rsp_err  = r_err;

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: scoreboard bench for imem_responder (LATENCY=3).
// Directed scenarios first, then randomized traffic against a word model.
module tb_imem_responder;

    localparam int          DL   = 12;
    localparam int          LAT  = 3;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] EBRK = 32'h0010_0073;
    localparam logic [31:0] W0   = 32'h0010_0093;
    localparam logic [31:0] W1   = 32'hDEAD_BEEF;
    localparam logic [31:0] WTOP = 32'hCAFE_0FFF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [31:0]   req_addr = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_inst;
    logic          rsp_err;
    logic          ld_wen = 1'b0;
    logic [DL-1:0] ld_addr = '0;
    logic [31:0]   ld_data = '0;
    logic          busy;

    imem_responder #(
        .DEPTH_LOG2(DL),
        .BASE_ADDR (BASE),
        .LATENCY   (LAT),
        .RESET_INST(NOP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_inst (rsp_inst),
        .rsp_err  (rsp_err),
        .ld_wen   (ld_wen),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
        logic [31:0] acc;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    exp_t        sbq[$];
    logic [31:0] model [1 << DL];
    logic [31:0] cyc = '0;
    logic [31:0] last_inst = '0;
    logic        last_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp,
                     $time);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting on DUT (t=%0t)", nm, $time);
    endtask

    // Reference: byte offset from base, one 32-bit word per 4 bytes.
    function automatic exp_t model_rsp(input logic [31:0] a);
        exp_t        e;
        logic [31:0] off;
        off   = a - BASE;
        e.acc = cyc;
`ifdef IMEM_BOUNDS_CHECK_EN
        if ((a % 4) != 0 || off >= 4 * (1 << DL)) begin
            e.inst = EBRK;
            e.err  = 1'b1;
        end else begin
            e.inst = model[off / 4];
            e.err  = 1'b0;
        end
`else
        e.inst = model[(off / 4) % (1 << DL)];
        e.err  = 1'b0;
`endif
        return e;
    endfunction

    // Issue side: every accepted request enqueues its expected response.
    always @(negedge clk) begin
        if (rst && req_valid && req_ready) begin
            sbq.push_back(model_rsp(req_addr));
        end
    end

    // Monitor side: compares each presented response with the queue head.
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic [31:0] pinst = '0;
    logic        perr = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            pv <= 1'b0;
            pr <= 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
                chk("hold_inst", rsp_inst, pinst);
                chk("hold_err", {31'd0, rsp_err}, {31'd0, perr});
            end
            if (rsp_valid && (!pv || pr)) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_rsp: got %h expected none",
                             rsp_inst);
                end else begin
                    chk("rsp_inst", rsp_inst, sbq[0].inst);
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, sbq[0].err});
                    chk("latency", cyc, sbq[0].acc + LAT);
                end
            end
            if (rsp_valid) begin
                chk("rsp_req_ready", {31'd0, req_ready},
                    {31'd0, rsp_ready});
                if (rsp_ready && sbq.size() != 0) begin
                    last_inst = rsp_inst;
                    last_err  = rsp_err;
                    void'(sbq.pop_front());
                end
            end
            if (!busy) begin
                chk("idle_inst", rsp_inst, NOP);
                chk("idle_ready", {31'd0, req_ready}, 32'd1);
            end
            pv    <= rsp_valid;
            pr    <= rsp_ready;
            pinst <= rsp_inst;
            perr  <= rsp_err;
        end
    end

    task automatic load(input int idx, input logic [31:0] d);
        ld_wen  = 1'b1;
        ld_addr = DL'(idx);
        ld_data = d;
        model[idx] = d;
        @(posedge clk);
        #1;
        ld_wen = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((busy || sbq.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a);
        int n = 0;
        req_valid = 1'b1;
        req_addr  = a;
        rsp_ready = 1'b1;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout("fetch_accept");
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_idle("fetch_done");
    endtask

    task automatic wait_rsp(input string nm);
        int n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) timeout(nm);
    endtask

    function automatic logic [31:0] rand_addr();
        unique case ($urandom_range(0, 4))
            0: return BASE + 4 * $urandom_range(0, 4095);
            1: return BASE + $urandom_range(0, 16383);
            2: return BASE - 4 * $urandom_range(1, 8);
            3: return BASE + 32'h4000 + 4 * $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2 rst = 1'b0;
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_inst", rsp_inst, NOP);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        @(posedge clk);
        #1;
        for (int i = 0; i < (1 << DL); i++) begin
            load(i, (i == 0) ? W0 : (i == 1) ? W1
                  : (i == (1 << DL) - 1) ? WTOP : $urandom);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Latency and busy profile with rsp_ready held high.
        req_valid = 1'b1;
        req_addr  = BASE;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("lat_busy", {31'd0, busy}, {31'd0, k <= 3});
            chk("lat_valid", {31'd0, rsp_valid}, {31'd0, k == 3});
            if (k == 3) chk("lat_inst", rsp_inst, W0);
        end
        wait_idle("lat_idle");

        // Stall in RESP for 4 cycles, then single handshake pulse.
        req_valid = 1'b1;
        req_addr  = BASE;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_rsp("stall_rsp");
        repeat (4) begin
            @(negedge clk);
            chk("stall_ready", {31'd0, req_ready}, 32'd0);
            chk("stall_inst", rsp_inst, W0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("post_busy", {31'd0, busy}, 32'd0);
        chk("post_inst", rsp_inst, NOP);
        wait_idle("stall_idle");

        // Back-to-back: accept word 1 on the response handshake edge.
        req_valid = 1'b1;
        req_addr  = BASE;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_rsp("b2b_first");
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = BASE + 32'd4;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("b2b_valid", {31'd0, rsp_valid}, {31'd0, k == 3});
            if (k == 3) chk("b2b_inst", rsp_inst, W1);
        end
        wait_idle("b2b_idle");

        // Address boundary cases.
        fetch(BASE + 32'd2);
`ifdef IMEM_BOUNDS_CHECK_EN
        chk("misalign_inst", last_inst, EBRK);
        chk("misalign_err", {31'd0, last_err}, 32'd1);
`else
        chk("misalign_inst", last_inst, W0);
`endif
        fetch(32'h7FFF_FFFC);
`ifdef IMEM_BOUNDS_CHECK_EN
        chk("below_err", {31'd0, last_err}, 32'd1);
`else
        chk("below_inst", last_inst, WTOP);
`endif
        fetch(32'h8000_4000);
`ifdef IMEM_BOUNDS_CHECK_EN
        chk("above_err", {31'd0, last_err}, 32'd1);
`else
        chk("above_inst", last_inst, W0);
`endif

        // Reset asserted while the request is in WAIT.
        req_valid = 1'b1;
        req_addr  = BASE + 32'd4;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        sbq.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("no_stale", {31'd0, rsp_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        fetch(BASE);
        chk("refetch_w0", last_inst, W0);
        fetch(BASE + 32'd4);
        chk("refetch_w1", last_inst, W1);

        // Randomized traffic with random back-pressure.
        for (int c = 0; c < 600; c++) begin
            req_valid = ($urandom_range(0, 2) != 0);
            req_addr  = rand_addr();
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle("drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
